barrel_shifter_pipe: RTL and testbench
======================================

// Module: barrel_shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter/rotator with valid/ready handshake on both sides.
//  Successor to the 8-bit combinational shifter: the width is a parameter, and it adds
//  arithmetic right shift, backpressure, a sideband tag and reserved-mode flagging.
//  Sits in the datapath between an operand producer (ALU issue) and a consumer (writeback).
//  Full throughput: one operation accepted per cycle when the output is not stalled.
// PARAMETERS
//  WIDTH   16             data width; power of 2, >= 4
//  SHW     $clog2(WIDTH)  shift-amount width; also the number of pipeline stages (derived)
//  TAG_W   4              width of the sideband tag carried alongside the data
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input operation valid
//  in_ready   out  1      block can accept; transfer occurs when in_valid && in_ready
//  in_data    in   WIDTH  operand
//  in_shamt   in   SHW    shift/rotate amount, 0..WIDTH-1
//  in_mode    in   3      000 LL, 001 LR, 010 RL, 011 RR, 100 ASR, 101-111 reserved
//  in_tag     in   TAG_W  opaque tag, returned unchanged with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer occurs when out_valid && out_ready
//  out_data   out  WIDTH  result
//  out_tag    out  TAG_W  tag of this result
//  out_err    out  1      1 = the operation used a reserved mode
// BEHAVIOUR
//  - Pipeline: SHW stages. Stage k conditionally shifts by 2^k when shamt bit k is 1.
//    Each stage registers: valid, data, shamt, mode, tag, err.
//  - Per-stage data rules:
//    - LL: zero fill on the right. LR: zero fill on the left.
//    - ASR: fill with the MSB. The MSB is invariant across stages, so the sign is preserved.
//    - RL/RR: bits wrap around, with no out-of-range shift term.
//  - shamt=0 returns in_data unchanged in every mode.
//  - Reserved mode: the data passes through unshifted, with out_err=1. The stage-0 register
//    captures err = (in_mode > 3'b100).
//  - Handshake:
//    - stage_rdy[k] = !v[k] || stage_rdy[k+1]; the last stage uses out_ready.
//    - in_ready = stage_rdy[0] && !rst.
//    - A stage loads from upstream when stage_rdy[k]; otherwise it holds.
//    - A bubble is inserted when upstream is not valid.
//  - Latency: exactly SHW cycles from accept to out_valid, with no stalls (WIDTH=16 -> 4).
//  - Stall: while out_valid && !out_ready, out_data, out_tag and out_err hold stable and
//    out_valid stays 1. Upstream stages fill bubbles, then freeze.
//  - Ordering: results leave in acceptance order. No loss and no duplication under any
//    pattern of in_valid or out_ready.
//  - Simultaneous events: accept and emit in the same cycle with a full pipe is legal.
//    in_ready stays 1 if out_ready=1.
//  - Reset (async assert, sync release by the system):
//    - All stage valids go to 0; data, tag and err registers go to 0.
//    - out_valid=0, out_data=0, out_tag=0, out_err=0 immediately.
//    - in_ready=0 while rst=1 and 1 in the first cycle after release.
//    - Reset mid-operation discards all in-flight operations. No result is emitted for them.
//  - out_* are driven directly from the last stage registers; there is no combinational
//    path from input data to output data.
// STRUCTURE
//  - Package barrel_shifter_pkg: localparams MODE_LL/LR/RL/RR/ASR (3-bit) and a function
//    is_reserved(mode).
//  - Sub-module bshift_stage #(WIDTH, SHW, TAG_W, STEP), generated SHW times with
//    STEP = 2^k. It contains one stage of shift logic, its register slice and the local
//    ready computation.
//  - The top level holds the generate loop, the ready chain and the stage-0 err decode.
// TESTING (WIDTH=16, TAG_W=4, results checked SHW=4 cycles after accept unless stalled)
//  1. LL in=16'h00F1, shamt=4, tag=3 -> out_data=16'h0F10, tag=3, err=0, out_valid in
//     cycle 4.
//  2. ASR in=16'h8000, shamt=15 -> 16'hFFFF; LR with the same operands -> 16'h0001;
//     ASR 16'h7FF0, shamt=4 -> 16'h07FF.
//  3. RR in=16'h0001, shamt=1 -> 16'h8000; RL 16'h8001, shamt=15 -> 16'hC000;
//     all five modes with shamt=0 -> unchanged.
//  4. 20 back-to-back random ops, out_ready=0 for 6 cycles mid-stream:
//     - in_ready drops after 4 stages fill;
//     - outputs are held stable during the stall;
//     - all 20 results match the model, in order, with tags intact.
//  5. Mode 3'b101, in=16'hA5A5, shamt=7 -> out_data=16'hA5A5, out_err=1; the next
//     valid-mode op -> out_err=0.
//  6. rst pulsed with 3 ops in flight -> out_valid=0 immediately, no results after
//     release, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation mode
// encodings and the reserved-mode decode used at the pipeline entry.
package barrel_shifter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LL  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_RL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_RR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ASR = 3'b100;

  // Every encoding above ASR is reserved; such operations pass through
  // unshifted and are flagged on out_err.
  function automatic logic is_reserved(input logic [MODE_W-1:0] mode);
    return (mode > MODE_ASR);
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Handshake bundle between the operand producer, the shifter and the
// result consumer. The shifter uses the slave modport; the producer and
// consumer side (the bench or the surrounding datapath) uses master.
interface barrel_shifter_pipe_if
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [SHW-1:0]    in_shamt;
  logic [MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/bshift_stage.sv
// One pipeline stage of the barrel shifter. It shifts or rotates the
// upstream operand by STEP positions when the matching shift-amount bit is
// set, then captures the result and its sideband in a register slice that
// stalls when the downstream stage cannot take it.
module bshift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int TAG_W = 4,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              up_valid,
  input  logic [WIDTH-1:0]  up_data,
  input  logic [SHW-1:0]    up_shamt,
  input  logic [MODE_W-1:0] up_mode,
  input  logic [TAG_W-1:0]  up_tag,
  input  logic              up_err,

  input  logic              dn_ready,

  output logic              v,
  output logic [WIDTH-1:0]  data,
  output logic [SHW-1:0]    shamt,
  output logic [MODE_W-1:0] mode,
  output logic [TAG_W-1:0]  tag,
  output logic              err,
  output logic              stage_rdy
);

  // The shift-amount bit this stage is responsible for.
  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] shifted;

  // This stage can take new data when it is empty or its content leaves.
  assign stage_rdy = !v || dn_ready;

  // Apply this stage's 2^k shift; reserved modes and a clear bit pass through.
  always_comb begin
    shifted = up_data;
    if (up_shamt[BIT] && !up_err) begin
      case (up_mode)
        MODE_LL:  shifted = {up_data[WIDTH-1-STEP:0], {STEP{1'b0}}};
        MODE_LR:  shifted = {{STEP{1'b0}}, up_data[WIDTH-1:STEP]};
        MODE_RL:  shifted = {up_data[WIDTH-1-STEP:0], up_data[WIDTH-1:WIDTH-STEP]};
        MODE_RR:  shifted = {up_data[STEP-1:0], up_data[WIDTH-1:STEP]};
        MODE_ASR: shifted = {{STEP{up_data[WIDTH-1]}}, up_data[WIDTH-1:STEP]};
        default:  shifted = up_data;
      endcase
    end
  end

  // Register slice: load (or insert a bubble) when ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= 1'b0;
      data  <= '0;
      shamt <= '0;
      mode  <= '0;
      tag   <= '0;
      err   <= 1'b0;
    end else if (stage_rdy) begin
      v <= up_valid;
      if (up_valid) begin
        data  <= shifted;
        shamt <= up_shamt;
        mode  <= up_mode;
        tag   <= up_tag;
        err   <= up_err;
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides. The
// operation flows through SHW stages, stage k handling shift bit k, so a
// result appears SHW cycles after acceptance when the consumer keeps up.
// Outputs come straight from the last stage registers.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  barrel_shifter_pipe_if.slave  bus
);

  // Index k is the input of stage k; index SHW is the last stage's output.
  logic [SHW:0]      v_c;
  logic [SHW:0]      err_c;
  logic [SHW:0]      rdy_c;
  logic [WIDTH-1:0]  data_c  [SHW+1];
  logic [SHW-1:0]    shamt_c [SHW+1];
  logic [MODE_W-1:0] mode_c  [SHW+1];
  logic [TAG_W-1:0]  tag_c   [SHW+1];

  // Ready chain closes on the consumer; the entry is blocked during reset.
  assign rdy_c[SHW]   = bus.out_ready;
  assign bus.in_ready = rdy_c[0] && !rst;

  // Entry point: only a real transfer enters stage 0, with its err decoded once.
  assign v_c[0]     = bus.in_valid && bus.in_ready;
  assign data_c[0]  = bus.in_data;
  assign shamt_c[0] = bus.in_shamt;
  assign mode_c[0]  = bus.in_mode;
  assign tag_c[0]   = bus.in_tag;
  assign err_c[0]   = is_reserved(bus.in_mode);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bshift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .TAG_W (TAG_W),
      .STEP  (2 ** k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (v_c[k]),
      .up_data   (data_c[k]),
      .up_shamt  (shamt_c[k]),
      .up_mode   (mode_c[k]),
      .up_tag    (tag_c[k]),
      .up_err    (err_c[k]),
      .dn_ready  (rdy_c[k+1]),
      .v         (v_c[k+1]),
      .data      (data_c[k+1]),
      .shamt     (shamt_c[k+1]),
      .mode      (mode_c[k+1]),
      .tag       (tag_c[k+1]),
      .err       (err_c[k+1]),
      .stage_rdy (rdy_c[k])
    );
  end

  assign bus.out_valid = v_c[SHW];
  assign bus.out_data  = data_c[SHW];
  assign bus.out_tag   = tag_c[SHW];
  assign bus.out_err   = err_c[SHW];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe at WIDTH=16, TAG_W=4. Directed operations
// carry hand-computed expectations; random operations are predicted by an
// arithmetic model. Every accepted operation queues its expectation and a
// monitor pops one per emitted result, so order, loss and duplication are
// all covered by the same check.
module tb_barrel_shifter_pipe;
  import barrel_shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic clk;
  logic rst;

  barrel_shifter_pipe_if #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) bus ();

  barrel_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t expQ[$];
  int   checkCount = 0;
  int   errCount   = 0;
  int   emitCount  = 0;
  bit   stopToggle = 0;

  logic             stallPrev = 0;
  logic [WIDTH-1:0] heldData;
  logic [TAG_W-1:0] heldTag;
  logic             heldErr;

  initial clk = 0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference model: plain arithmetic on 32-bit values, masked to 16 bits.
  function automatic logic [WIDTH:0] refShift(input logic [WIDTH-1:0] d, input int s, input logic [2:0] m);
    int unsigned x = d;
    int signed   sx;
    int unsigned r;
    if (m > 3'd4) return {1'b1, d};
    case (m)
      3'd0: r = x << s;
      3'd1: r = x >> s;
      3'd2: r = (x << s) | (x >> (WIDTH - s));
      3'd3: r = (x >> s) | (x << (WIDTH - s));
      default: begin
        sx = d[WIDTH-1] ? int'(x | 32'hFFFF_0000) : int'(x);
        r  = unsigned'(sx >>> s);
      end
    endcase
    return {1'b0, r[WIDTH-1:0]};
  endfunction

  // Present one operation, wait for the transfer and queue its expectation.
  // Returns one step after the transfer edge with in_valid still asserted.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                               input logic [2:0] m, input logic [TAG_W-1:0] t,
                               input logic [WIDTH-1:0] expD, input logic expE);
    bit accepted = 0;
    bus.in_valid = 1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    bus.in_tag   = t;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (accepted) expQ.push_back('{data: expD, tag: t, err: expE});
    else checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic endStimulus();
    bus.in_valid = 0;
  endtask

  task automatic applyRandom(input logic [TAG_W-1:0] t);
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   s;
    logic [2:0]       m;
    logic [WIDTH:0]   r;
    d = WIDTH'($urandom);
    s = SHW'($urandom_range(0, WIDTH - 1));
    m = 3'($urandom_range(0, 5));
    if (m == 3'd5) m = 3'($urandom_range(5, 7));
    r = refShift(d, int'(s), m);
    applyStimulus(d, s, m, t, r[WIDTH-1:0], r[WIDTH]);
  endtask

  // Wait until every queued expectation has been matched by an output.
  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_complete", expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stallPrev <= 0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid_hold", bus.out_valid, 1);
        checkOutput("stall_data_hold", bus.out_data, heldData);
        checkOutput("stall_tag_hold", bus.out_tag, heldTag);
        checkOutput("stall_err_hold", bus.out_err, heldErr);
      end
      if (bus.out_valid && bus.out_ready) begin
        emitCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("result_data", bus.out_data, e.data);
          checkOutput("result_tag", bus.out_tag, e.tag);
          checkOutput("result_err", bus.out_err, e.err);
        end
      end
      stallPrev <= bus.out_valid && !bus.out_ready;
      heldData  <= bus.out_data;
      heldTag   <= bus.out_tag;
      heldErr   <= bus.out_err;
    end
  end

  initial begin
    int lat;
    int startEmit;
    logic [WIDTH-1:0] unchangedVal;

    rst = 1;
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_data", bus.out_data, 0);
    checkOutput("reset_out_tag", bus.out_tag, 0);
    checkOutput("reset_out_err", bus.out_err, 0);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed LL with latency check");
    applyStimulus(16'h00F1, 4'd4, MODE_LL, 4'd3, 16'h0F10, 1'b0);
    endStimulus();
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("latency_cycles", lat, SHW);
    drain(50);

    $display("[TB] directed ASR/LR/rotate and shamt=0 cases");
    applyStimulus(16'h8000, 4'd15, MODE_ASR, 4'd1, 16'hFFFF, 1'b0);
    applyStimulus(16'h8000, 4'd15, MODE_LR,  4'd2, 16'h0001, 1'b0);
    applyStimulus(16'h7FF0, 4'd4,  MODE_ASR, 4'd4, 16'h07FF, 1'b0);
    applyStimulus(16'h0001, 4'd1,  MODE_RR,  4'd5, 16'h8000, 1'b0);
    applyStimulus(16'h8001, 4'd15, MODE_RL,  4'd6, 16'hC000, 1'b0);
    applyStimulus(16'h8001, 4'd3,  MODE_LL,  4'd7, 16'h0008, 1'b0);
    applyStimulus(16'hF00F, 4'd8,  MODE_RR,  4'd8, 16'h0FF0, 1'b0);
    unchangedVal = 16'hB38D;
    for (int m = 0; m < 5; m++)
      applyStimulus(unchangedVal, 4'd0, 3'(m), 4'(9 + m), unchangedVal, 1'b0);
    endStimulus();
    drain(60);

    $display("[TB] reserved mode then valid mode");
    applyStimulus(16'hA5A5, 4'd7, 3'b101, 4'hE, 16'hA5A5, 1'b1);
    applyStimulus(16'h0001, 4'd1, MODE_LL, 4'hF, 16'h0002, 1'b0);
    applyStimulus(16'h1234, 4'd5, 3'b111, 4'h2, 16'h1234, 1'b1);
    endStimulus();
    drain(50);

    $display("[TB] 20 back-to-back random ops with a 6-cycle stall");
    startEmit = emitCount;
    fork
      begin
        for (int i = 0; i < 20; i++) applyRandom(4'(i));
        endStimulus();
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("full_flow_out_valid", bus.out_valid, 1);
        checkOutput("full_flow_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("stalled_in_ready", bus.in_ready, 0);
        checkOutput("stalled_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain(100);
    checkOutput("burst_result_count", emitCount - startEmit, 20);

    $display("[TB] random ops with gaps and random backpressure");
    startEmit = emitCount;
    fork
      begin
        while (!stopToggle) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      applyRandom(4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        endStimulus();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    endStimulus();
    drain(400);
    stopToggle = 1;
    @(posedge clk);
    #2 bus.out_ready = 1;
    checkOutput("random_result_count", emitCount - startEmit, 30);

    $display("[TB] reset with operations in flight");
    applyStimulus(16'h1111, 4'd1, MODE_LL, 4'd1, 16'h2222, 1'b0);
    applyStimulus(16'h2222, 4'd1, MODE_LL, 4'd2, 16'h4444, 1'b0);
    applyStimulus(16'h3333, 4'd1, MODE_LL, 4'd3, 16'h6666, 1'b0);
    endStimulus();
    @(posedge clk);
    #1;
    checkOutput("pre_reset_out_valid", bus.out_valid, 1);
    #1 rst = 1;
    expQ.delete();
    #1;
    checkOutput("async_reset_out_valid", bus.out_valid, 0);
    checkOutput("async_reset_out_data", bus.out_data, 0);
    checkOutput("async_reset_out_tag", bus.out_tag, 0);
    checkOutput("async_reset_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", bus.in_ready, 1);
    startEmit = emitCount;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("post_reset_no_results", emitCount - startEmit, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
